// File: rtl/usr_regbank.sv
// Parametrised user register bank on the reg_* strobe bus: control, scratch,
// sticky W1C events with masked IRQ, self-clearing pulses and coherent status snapshots.
module usr_regbank #(
    parameter int                   ADDR_W    = 8,
    parameter int                   NUM_CTL   = 4,
    parameter int                   NUM_STS   = 8,
    parameter int                   NUM_EVT   = 8,
    parameter logic [NUM_CTL*32-1:0] CTL_RST  = {NUM_CTL{32'h0}},
    parameter logic [31:0]          BLOCK_ID  = 32'h5245_4701,
    parameter logic [31:0]          DEAD_WORD = 32'hDEAD_BEEF
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_resetn,
    input  logic [ADDR_W-1:0]     reg_addr,
    input  logic [31:0]           reg_wdata,
    input  logic [3:0]            reg_wstrb,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    output logic [31:0]           reg_rdata,
    output logic                  reg_rvalid,
    output logic [NUM_CTL*32-1:0] ctl_o,
    input  logic [NUM_STS*32-1:0] sts_i,
    input  logic [NUM_EVT-1:0]    evt_i,
    output logic [31:0]           pulse_o,
    output logic                  irq_o
);

    // Bus semantics: reg_wr and reg_rd are single-cycle strobes with no backpressure.
    // A read strobe in cycle N always yields reg_rvalid for exactly cycle N+1;
    // reg_rdata is only meaningful while reg_rvalid is high and holds otherwise.

    localparam logic [31:0] A_ID      = 32'h00;
    localparam logic [31:0] A_SCRATCH = 32'h01;
    localparam logic [31:0] A_EVT_STS = 32'h02;
    localparam logic [31:0] A_EVT_MSK = 32'h03;
    localparam logic [31:0] A_PULSE   = 32'h04;
    localparam logic [31:0] A_SNAP    = 32'h05;
    localparam logic [31:0] A_CTL     = 32'h10;
    localparam logic [31:0] A_STS     = 32'h40;

    logic [31:0]        ctl [NUM_CTL];
    logic [31:0]        snap [NUM_STS];
    logic [31:0]        scratch;
    logic [NUM_EVT-1:0] evt_status;
    logic [NUM_EVT-1:0] evt_mask;

    logic [31:0]        addr;
    logic [NUM_EVT-1:0] w1c;
    logic [31:0]        evt_status_w;
    logic [31:0]        evt_mask_w;
    logic [31:0]        rd_mux;

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    assign addr = 32'(reg_addr);
    assign w1c  = (reg_wr && addr == A_EVT_STS) ? reg_wdata[NUM_EVT-1:0] : '0;

    for (genvar k = 0; k < NUM_CTL; k++) begin : g_ctl_out
        assign ctl_o[32*k +: 32] = ctl[k];
    end

    always_comb begin
        evt_status_w = '0;
        evt_mask_w   = '0;
        evt_status_w[NUM_EVT-1:0] = evt_status;
        evt_mask_w[NUM_EVT-1:0]   = evt_mask;
    end

    // Read mux sees register state before this cycle's write, so read-during-write
    // to the same word returns the old value.
    always_comb begin
        rd_mux = DEAD_WORD;
        case (addr)
            A_ID:      rd_mux = BLOCK_ID;
            A_SCRATCH: rd_mux = scratch;
            A_EVT_STS: rd_mux = evt_status_w;
            A_EVT_MSK: rd_mux = evt_mask_w;
            A_PULSE:   rd_mux = 32'h0;
            A_SNAP:    rd_mux = 32'h0;
            default:   rd_mux = DEAD_WORD;
        endcase
        for (int k = 0; k < NUM_CTL; k++) begin
            if (addr == A_CTL + 32'(k)) rd_mux = ctl[k];
        end
        for (int j = 0; j < NUM_STS; j++) begin
            if (addr == A_STS + 32'(j)) rd_mux = snap[j];
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            for (int k = 0; k < NUM_CTL; k++) ctl[k] <= CTL_RST[32*k +: 32];
            for (int j = 0; j < NUM_STS; j++) snap[j] <= '0;
            scratch    <= '0;
            evt_status <= '0;
            evt_mask   <= '0;
            pulse_o    <= '0;
            irq_o      <= 1'b0;
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            // Set wins over clear: evt_i is ORed in after the W1C mask.
            evt_status <= (evt_status & ~w1c) | evt_i;
            irq_o      <= |(evt_status & evt_mask);
            pulse_o    <= (reg_wr && addr == A_PULSE) ? reg_wdata : 32'h0;
            reg_rvalid <= reg_rd;
            if (reg_rd) reg_rdata <= rd_mux;

            if (reg_wr) begin
                if (addr == A_SCRATCH) scratch  <= apply_strb(scratch, reg_wdata, reg_wstrb);
                if (addr == A_EVT_MSK) evt_mask <= reg_wdata[NUM_EVT-1:0];
                if (addr == A_SNAP) begin
                    for (int j = 0; j < NUM_STS; j++) snap[j] <= sts_i[32*j +: 32];
                end
                for (int k = 0; k < NUM_CTL; k++) begin
                    if (addr == A_CTL + 32'(k)) ctl[k] <= apply_strb(ctl[k], reg_wdata, reg_wstrb);
                end
            end
        end
    end

endmodule

// File: doc/usr_regbank.md
Name: usr_regbank

Overview:
- Parametrised successor of the board user-register block; sits behind the AXI4-Lite slave adapter on its reg_addr/reg_wdata/reg_wr/reg_rd user bus.
- Provides NUM_CTL byte-strobed control registers, NUM_STS status registers read through a coherent snapshot, NUM_EVT sticky write-1-to-clear event bits with mask and level IRQ, self-clearing pulse bits, a scratch register, and a defined read-data valid strobe.
- Replaces the hand-listed per-register decode with an indexed map, so channel counts change through parameters only.

Parameters:
- ADDR_W, 8, word-address width of reg_addr.
- NUM_CTL, 4, number of 32-bit control registers (1..16).
- NUM_STS, 8, number of 32-bit status inputs (1..32).
- NUM_EVT, 8, number of sticky event bits (1..32).
- CTL_RST, {NUM_CTL{32'h0}}, flat reset value of the control registers; CTL k uses bits [32k+31:32k].
- BLOCK_ID, 32'h5245_4701, value returned at the ID word.
- DEAD_WORD, 32'hDEAD_BEEF, value returned for unmapped reads.

Ports:
- s_axi_clk, in, 1, clock.
- s_axi_resetn, in, 1, asynchronous active-low reset.
- reg_addr, in, ADDR_W, word address.
- reg_wdata, in, 32, write data.
- reg_wstrb, in, 4, byte enables for reg_wdata.
- reg_wr, in, 1, single-cycle write strobe.
- reg_rd, in, 1, single-cycle read strobe.
- reg_rdata, out, 32, read data.
- reg_rvalid, out, 1, read data valid, one cycle.
- ctl_o, out, NUM_CTL*32, control register contents.
- sts_i, in, NUM_STS*32, status inputs, synchronous to s_axi_clk.
- evt_i, in, NUM_EVT, event set pulses or levels.
- pulse_o, out, 32, self-clearing command pulses.
- irq_o, out, 1, OR of (evt_status & evt_mask), registered.

Behaviour:
- Word map (reg_addr):
  - 0x00 ID, RO.
  - 0x01 SCRATCH, RW, byte-strobed.
  - 0x02 EVT_STATUS, RO / W1C.
  - 0x03 EVT_MASK, RW.
  - 0x04 PULSE, WO, reads back 0.
  - 0x05 SNAP, WO; any write captures the snapshot.
  - 0x10+k CTL[k], RW, byte-strobed, k < NUM_CTL.
  - 0x40+k STS_SNAP[k], RO, k < NUM_STS.
  - Everything else: writes ignored, reads return DEAD_WORD.
- Reset values:
  - ctl_o = CTL_RST; scratch = 0; evt_status = 0; evt_mask = 0.
  - Snapshot array = 0; pulse_o = 0; irq_o = 0; reg_rdata = 0; reg_rvalid = 0.
  - Reset asserted mid-operation clears all of these immediately; a read in flight produces no reg_rvalid.
- Writes take effect on the clock edge where reg_wr = 1. For byte-strobed registers, byte b is updated only when reg_wstrb[b] = 1.
- Reads have fixed latency 1: reg_rd at cycle N gives reg_rdata plus reg_rvalid = 1 at cycle N+1. reg_rvalid = 0 otherwise; reg_rdata holds its last value.
- reg_rd and reg_wr both high in one cycle to the same address: the read returns the pre-write value.
- Events: each cycle, evt_status <= (evt_status & ~w1c) | evt_i.
  - w1c = reg_wdata[NUM_EVT-1:0] on a write to 0x02, else 0.
  - Set wins over clear in the same cycle.
  - Bits at and above NUM_EVT read 0.
- irq_o = |(evt_status & evt_mask), registered, so it lags the status change by one cycle.
- PULSE: a write drives pulse_o = reg_wdata for exactly one cycle, then 0. Back-to-back writes give back-to-back pulses.
- SNAP: a write copies all sts_i into the snapshot array on that edge. STS reads return the snapshot, never live sts_i, so multi-word counters are read coherently. A SNAP write and an STS read in the same cycle return the old snapshot.
- Index decode applies range checks against NUM_CTL and NUM_STS. Addresses beyond the parameter range behave as unmapped.

Test Plan:
- Reset check: release reset with CTL_RST[31:0] = 32'h0000_00A5 -> ctl_o[31:0] = 32'hA5, irq_o = 0; read 0x00 -> 32'h5245_4701 with reg_rvalid exactly one cycle after reg_rd.
- Byte strobes: write 0x10 with data 32'h1122_3344, wstrb 4'b0101 starting from 0 -> ctl_o[31:0] = 32'h0022_0044; read 0x10 returns the same value; read 0x0F -> 32'hDEAD_BEEF.
- Events and IRQ:
  - Pulse evt_i[3] -> EVT_STATUS = 32'h8.
  - Write EVT_MASK = 8 -> irq_o = 1 one cycle later.
  - W1C write of 8 in the same cycle as a new evt_i[3] pulse -> bit stays set.
  - W1C write of 8 with no event -> bit clears, irq_o falls next cycle.
- Pulse register: write 0x04 = 32'h0000_0003 -> pulse_o = 3 for one cycle, then 0; a following read of 0x04 returns 0.
- Snapshot coherency:
  - Set sts_i[31:0] = 100, write SNAP, then change sts_i[31:0] to 200 -> read 0x40 returns 100.
  - Write SNAP again -> read 0x40 returns 200.
- Asynchronous reset: assert s_axi_resetn low between reg_rd and the following edge -> no reg_rvalid; all outputs return to reset values without a clock edge.
